stream_border_pad: RTL and testbench

Parametrised border-insertion stage between the demosaic output and the sliding-window filter. It accepts a raster stream of WIDTH×HEIGHT multi-channel pixels and emits a (WIDTH+2B)×(HEIGHT+2B) stream, where B=(KERNEL-1)/2. Top and bottom rows are always zero; left and right columns are zero or edge-replicated, selected per frame. An input-side ready handshake stalls upstream while pad pixels are being inserted.

---
 rtl/isp_pad_pkg.sv | 24 ++
 rtl/pad_xy_counter.sv | 55 +++++
 rtl/stream_border_pad.sv | 141 ++++++++++++++
 tb/tb_stream_border_pad.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/isp_pad_pkg.sv
// Shared types and sizing helpers for the stream border-pad stage.
package isp_pad_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_TOP    = 3'd1,
      S_LEFT   = 3'd2,
      S_BODY   = 3'd3,
      S_RIGHT  = 3'd4,
      S_BOTTOM = 3'd5
   } pad_state_t;

   localparam logic PAD_ZERO = 1'b0;
   localparam logic PAD_REPL = 1'b1;

   function automatic int pad_border(input int kernel);
      return (kernel - 1) / 2;
   endfunction

   function automatic int frame_size(input int width, input int height, input int kernel);
      return (height + 2 * pad_border(kernel)) * (width + 2 * pad_border(kernel));
   endfunction

endpackage

// File: rtl/pad_xy_counter.sv
// Output-raster position counters plus the region-boundary flags the pad FSM steers by.
module pad_xy_counter #(
   parameter int WIDTH  = 320,
   parameter int HEIGHT = 240,
   parameter int B      = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        step,
   output logic [31:0] idx,
   output logic        col_first,
   output logic        col_left_end,
   output logic        col_repl_end,
   output logic        col_body_end,
   output logic        col_last,
   output logic        row_top_end,
   output logic        row_body_end,
   output logic        frame_end
);

   localparam int OW = WIDTH + 2 * B;
   localparam int OH = HEIGHT + 2 * B;
   localparam int CW = $clog2(OW + 1);
   localparam int RW = $clog2(OH + 1);

   logic [CW-1:0] col;
   logic [RW-1:0] row;

   // All flags describe the position of the next pixel to be emitted.
   assign col_first    = (col == CW'(0));
   assign col_left_end = (col == CW'(B - 1));
   assign col_repl_end = (col == CW'(B));
   assign col_body_end = (col == CW'(B + WIDTH - 1));
   assign col_last     = (col == CW'(OW - 1));
   assign row_top_end  = (row == RW'(B - 1));
   assign row_body_end = (row == RW'(B + HEIGHT - 1));
   assign frame_end    = col_last && (row == RW'(OH - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         col <= '0;
         row <= '0;
         idx <= '0;
      end else if (step) begin
         if (col_last) begin
            col <= '0;
            row <= (row == RW'(OH - 1)) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
         idx <= frame_end ? '0 : idx + 32'd1;
      end
   end

endmodule

// File: rtl/stream_border_pad.sv
// Border-insertion stage: wraps a WIDTHxHEIGHT pixel stream with B rows/columns of
// zero or edge-replicated padding, stalling upstream while pad pixels are inserted.
module stream_border_pad
   import isp_pad_pkg::*;
#(
   parameter int WIDTH  = 320,
   parameter int HEIGHT = 240,
   parameter int KERNEL = 7,
   parameter int CH     = 3,
   parameter int DW     = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                newFrame,
   input  logic                mode,
   input  logic                iValid,
   output logic                iReady,
   input  logic [CH*DW-1:0]    iData,
   output logic                oValid,
   output logic [CH*DW-1:0]    oData,
   output logic [31:0]         oCnt,
   output logic                oDone,
   output logic [2:0]          fsm_state
);

   localparam int B  = pad_border(KERNEL);
   localparam int PW = CH * DW;

   pad_state_t    state, nstate, act;
   logic          mode_q, repl;
   logic [PW-1:0] edge_q, pix_nxt;
   logic          emit, load_edge, done_nxt, ready_nxt, xfer;
   logic [31:0]   idx;
   logic          col_first, col_left_end, col_repl_end, col_body_end, col_last;
   logic          row_top_end, row_body_end, frame_end;

   // Input handshake: a pixel moves when iValid && iReady in the same cycle; iReady is
   // registered and never depends on iValid. The output side has no back-pressure.
   assign xfer      = iValid && iReady;
   assign fsm_state = state;

   pad_xy_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .B(B)) u_xy (
      .clk          (clk),
      .reset        (reset),
      .step         (emit),
      .idx          (idx),
      .col_first    (col_first),
      .col_left_end (col_left_end),
      .col_repl_end (col_repl_end),
      .col_body_end (col_body_end),
      .col_last     (col_last),
      .row_top_end  (row_top_end),
      .row_body_end (row_body_end),
      .frame_end    (frame_end)
   );

   // A newFrame in IDLE behaves as the first TOP cycle so pixel 0 leaves one cycle later.
   always_comb begin
      act       = (state == S_IDLE && newFrame) ? S_TOP : state;
      repl      = (state == S_IDLE) ? (mode == PAD_REPL) : (mode_q == PAD_REPL);
      nstate    = act;
      emit      = 1'b0;
      load_edge = 1'b0;
      done_nxt  = 1'b0;
      pix_nxt   = '0;
      case (act)
         S_IDLE: nstate = S_IDLE;
         S_TOP: begin
            emit = 1'b1;
            if (row_top_end && col_last) nstate = S_LEFT;
         end
         S_LEFT: begin
            if (!repl) begin
               emit = 1'b1;
               if (col_left_end) nstate = S_BODY;
            end else if (col_first) begin
               if (xfer) begin
                  emit      = 1'b1;
                  load_edge = 1'b1;
                  pix_nxt   = iData;
               end
            end else begin
               // The final copy at column B is the real x=0 pixel.
               emit    = 1'b1;
               pix_nxt = edge_q;
               if (col_repl_end) nstate = S_BODY;
            end
         end
         S_BODY: begin
            if (xfer) begin
               emit      = 1'b1;
               load_edge = 1'b1;
               pix_nxt   = iData;
               if (col_body_end) nstate = S_RIGHT;
            end
         end
         S_RIGHT: begin
            emit    = 1'b1;
            pix_nxt = repl ? edge_q : '0;
            if (col_last) nstate = row_body_end ? S_BOTTOM : S_LEFT;
         end
         S_BOTTOM: begin
            emit = 1'b1;
            if (frame_end) begin
               nstate   = S_IDLE;
               done_nxt = 1'b1;
            end
         end
         default: nstate = S_IDLE;
      endcase
      ready_nxt = (nstate == S_BODY) ||
                  (nstate == S_LEFT && repl && !(act == S_LEFT && emit));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         mode_q <= PAD_ZERO;
         edge_q <= '0;
         iReady <= 1'b0;
         oValid <= 1'b0;
         oData  <= '0;
         oCnt   <= '0;
         oDone  <= 1'b0;
      end else begin
         state  <= nstate;
         iReady <= ready_nxt;
         oValid <= emit;
         oDone  <= done_nxt;
         if (state == S_IDLE && newFrame) mode_q <= mode;
         if (load_edge) edge_q <= iData;
         if (emit) begin
            oData <= pix_nxt;
            oCnt  <= idx;
         end else if (state == S_IDLE) begin
            oCnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_stream_border_pad.sv
// Directed bench for stream_border_pad: a 4x3 instance driven from a scenario table
// and a default-size instance checked for frame totals.
module tb_stream_border_pad;

   logic        clk = 1'b0;
   logic        reset;
   logic        newFrame, mode, iValid, iReady;
   logic [23:0] iData, oData;
   logic        oValid, oDone;
   logic [31:0] oCnt;
   logic [2:0]  fsm_state;

   logic        big_nf, big_valid, big_ready, big_ovalid, big_odone;
   logic [23:0] big_data, big_odata;
   logic [31:0] big_ocnt;
   logic [2:0]  big_state;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   stream_border_pad #(.WIDTH(4), .HEIGHT(3), .KERNEL(3), .CH(3), .DW(8)) dut (
      .clk(clk), .reset(reset), .newFrame(newFrame), .mode(mode),
      .iValid(iValid), .iReady(iReady), .iData(iData),
      .oValid(oValid), .oData(oData), .oCnt(oCnt), .oDone(oDone),
      .fsm_state(fsm_state)
   );

   stream_border_pad dut_big (
      .clk(clk), .reset(reset), .newFrame(big_nf), .mode(1'b0),
      .iValid(big_valid), .iReady(big_ready), .iData(big_data),
      .oValid(big_ovalid), .oData(big_odata), .oCnt(big_ocnt), .oDone(big_odone),
      .fsm_state(big_state)
   );

   typedef struct {
      string name;
      logic  mode;
      bit    gaps;
      int    abort_at;
      bit    pulse_nf;
   } scen_t;

   scen_t       scen[8];
   int          tbl_zero[30];
   int          tbl_repl[30];
   logic [23:0] exp_q[$];
   logic [23:0] cap_data[$];
   logic [31:0] cap_cnt[$];
   logic        cap_done[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [23:0] pix(input int n);
      logic [7:0] b;
      b = n[7:0];
      return {b, b, b};
   endfunction

   task automatic run_frame(input scen_t s);
      int  k = 0;
      int  xfers = 0;
      bit  done_seen = 0;
      cap_data.delete();
      cap_cnt.delete();
      cap_done.delete();
      newFrame = 1'b1;
      mode     = s.mode;
      iValid   = 1'b0;
      @(negedge clk);
      newFrame = 1'b0;
      check({s.name, "_first_valid"}, 32'(oValid), 32'd1);
      for (int cyc = 0; cyc < 200 && !done_seen; cyc++) begin
         if (oValid) begin
            cap_data.push_back(oData);
            cap_cnt.push_back(oCnt);
            cap_done.push_back(oDone);
            if (oDone) done_seen = 1;
         end
         if (s.abort_at >= 0 && oValid && oCnt == 32'(s.abort_at)) begin
            reset  = 1'b1;
            iValid = 1'b0;
            @(negedge clk);
            reset = 1'b0;
            check({s.name, "_rst_ovalid"}, 32'(oValid), 32'd0);
            check({s.name, "_rst_iready"}, 32'(iReady), 32'd0);
            check({s.name, "_rst_ocnt"}, oCnt, 32'd0);
            check({s.name, "_rst_state"}, 32'(fsm_state), 32'd0);
            return;
         end
         newFrame = s.pulse_nf && oValid && (oCnt == 32'd8);
         mode     = newFrame ? ~s.mode : s.mode;
         iValid   = s.gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         iData    = pix(k + 1);
         if (iValid && iReady) begin
            k++;
            xfers++;
         end
         @(negedge clk);
      end
      iValid   = 1'b0;
      newFrame = 1'b0;
      check({s.name, "_done_seen"}, 32'(done_seen), 32'd1);
      check({s.name, "_xfers"}, 32'(xfers), 32'd12);
   endtask

   task automatic check_frame(input scen_t s);
      int n;
      exp_q.delete();
      for (int i = 0; i < 30; i++) exp_q.push_back(pix(s.mode ? tbl_repl[i] : tbl_zero[i]));
      check({s.name, "_count"}, 32'(cap_data.size()), 32'd30);
      n = (cap_data.size() < 30) ? cap_data.size() : 30;
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_data%0d", s.name, i), 32'(cap_data[i]), 32'(exp_q.pop_front()));
         check($sformatf("%s_cnt%0d", s.name, i), cap_cnt[i], 32'(i));
         check($sformatf("%s_done%0d", s.name, i), 32'(cap_done[i]), 32'(i == 29));
      end
   endtask

   initial begin
      int big_cnt, big_xfers, big_bad, big_done_at;

      tbl_zero = '{0, 0, 0, 0, 0, 0,
                   0, 1, 2, 3, 4, 0,
                   0, 5, 6, 7, 8, 0,
                   0, 9, 10, 11, 12, 0,
                   0, 0, 0, 0, 0, 0};
      tbl_repl = '{0, 0, 0, 0, 0, 0,
                   1, 1, 2, 3, 4, 4,
                   5, 5, 6, 7, 8, 8,
                   9, 9, 10, 11, 12, 12,
                   0, 0, 0, 0, 0, 0};
      scen[0] = '{"zero", 1'b0, 1'b0, -1, 1'b0};
      scen[1] = '{"repl", 1'b1, 1'b0, -1, 1'b0};
      scen[2] = '{"zero_gap", 1'b0, 1'b1, -1, 1'b0};
      scen[3] = '{"repl_gap", 1'b1, 1'b1, -1, 1'b0};
      scen[4] = '{"abort", 1'b0, 1'b0, 15, 1'b0};
      scen[5] = '{"after_rst", 1'b0, 1'b0, -1, 1'b0};
      scen[6] = '{"nf_body", 1'b0, 1'b0, -1, 1'b1};
      scen[7] = '{"nf_repl_gap", 1'b1, 1'b1, -1, 1'b1};

      reset = 1'b1;
      newFrame = 1'b0; mode = 1'b0; iValid = 1'b0; iData = '0;
      big_nf = 1'b0; big_valid = 1'b0; big_data = 24'hA5A5A5;
      repeat (3) @(negedge clk);
      check("rst_iready", 32'(iReady), 32'd0);
      check("rst_ovalid", 32'(oValid), 32'd0);
      check("rst_odata", 32'(oData), 32'd0);
      check("rst_ocnt", oCnt, 32'd0);
      check("rst_odone", 32'(oDone), 32'd0);
      check("rst_state", 32'(fsm_state), 32'd0);
      newFrame = 1'b1;
      @(negedge clk);
      newFrame = 1'b0;
      check("rst_beats_nf", 32'(oValid), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         run_frame(scen[i]);
         if (scen[i].abort_at < 0) check_frame(scen[i]);
         repeat (2) @(negedge clk);
      end

      big_nf = 1'b1;
      @(negedge clk);
      big_nf = 1'b0;
      big_valid = 1'b1;
      big_cnt = 0; big_xfers = 0; big_bad = 0; big_done_at = -1;
      for (int cyc = 0; cyc < 81000 && big_done_at < 0; cyc++) begin
         if (big_ovalid) begin
            if (big_ocnt != 32'(big_cnt)) big_bad++;
            if (big_odone) big_done_at = int'(big_ocnt);
            big_cnt++;
         end
         if (big_ready) big_xfers++;
         @(negedge clk);
      end
      big_valid = 1'b0;
      check("big_count", 32'(big_cnt), 32'd80196);
      check("big_done_at", 32'(big_done_at), 32'd80195);
      check("big_xfers", 32'(big_xfers), 32'd76800);
      check("big_ocnt_seq", 32'(big_bad), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
